// File: rtl/ddot_lane_packer.sv
// ddot_lane_packer: packs a serial stream of (x, y) element pairs into 8-lane groups for the
// 8-lane dot-product stage. Short groups closed by in_last are padded with PAD_VALUE.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   in_valid/in_ready   upstream element handshake
//   in_x, in_y          element pair
//   in_last             closes the current group
//   ready               one-cycle strobe: a new group is on x0..x7 / y0..y7
//   out_last            group issued with this strobe was closed by in_last
//   x0..x7, y0..y7      packed lanes, lane 0 is the oldest element
//   group_count         (DDOT_PACK_STATS_EN) issued groups, wrapping
//   pad_count           (DDOT_PACK_STATS_EN) padded lanes issued, saturating
//
// Optional feature: define DDOT_PACK_STATS_EN to add group_count / pad_count.
module ddot_lane_packer #(
   parameter int unsigned       DATA_W    = 32,
   parameter logic [DATA_W-1:0] PAD_VALUE = '0,
   parameter int unsigned       MIN_GAP   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   input  logic              in_last,
   output logic              ready,
   output logic              out_last,
   output logic [DATA_W-1:0] x0,
   output logic [DATA_W-1:0] x1,
   output logic [DATA_W-1:0] x2,
   output logic [DATA_W-1:0] x3,
   output logic [DATA_W-1:0] x4,
   output logic [DATA_W-1:0] x5,
   output logic [DATA_W-1:0] x6,
   output logic [DATA_W-1:0] x7,
   output logic [DATA_W-1:0] y0,
   output logic [DATA_W-1:0] y1,
   output logic [DATA_W-1:0] y2,
   output logic [DATA_W-1:0] y3,
   output logic [DATA_W-1:0] y4,
   output logic [DATA_W-1:0] y5,
   output logic [DATA_W-1:0] y6,
   output logic [DATA_W-1:0] y7
`ifdef DDOT_PACK_STATS_EN
   ,
   output logic [15:0]       group_count,
   output logic [15:0]       pad_count
`endif
);

   localparam logic [7:0] GapReload = 8'(MIN_GAP - 1);

   logic [DATA_W-1:0] fill_x_q [8];
   logic [DATA_W-1:0] fill_x_d [8];
   logic [DATA_W-1:0] fill_y_q [8];
   logic [DATA_W-1:0] fill_y_d [8];
   logic [DATA_W-1:0] out_x_q  [8];
   logic [DATA_W-1:0] out_x_d  [8];
   logic [DATA_W-1:0] out_y_q  [8];
   logic [DATA_W-1:0] out_y_d  [8];
   logic [2:0]        idx_q, idx_d;
   logic [2:0]        pend_idx_q, pend_idx_d;
   logic              pend_last_q, pend_last_d;
   logic              pending_q, pending_d;
   logic [7:0]        gap_q, gap_d;
   logic              ready_q, ready_d;
   logic              out_last_q, out_last_d;
`ifdef DDOT_PACK_STATS_EN
   logic [15:0]       group_count_q, group_count_d;
   logic [15:0]       pad_count_q, pad_count_d;
   logic [16:0]       pad_sum;
`endif

   logic              accept;
   logic              complete;
   logic              issue;
   logic [2:0]        last_idx;
   logic              group_last;

   assign in_ready = ~pending_q;

   always_comb begin
      accept     = in_valid && in_ready;
      complete   = accept && ((idx_q == 3'd7) || in_last);
      issue      = (complete || pending_q) && (gap_q == 8'd0);
      // A held group already has its completing element stored in the fill lanes.
      last_idx   = pending_q ? pend_idx_q : idx_q;
      group_last = pending_q ? pend_last_q : in_last;

      fill_x_d    = fill_x_q;
      fill_y_d    = fill_y_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      idx_d       = idx_q;
      pend_idx_d  = pend_idx_q;
      pend_last_d = pend_last_q;
      pending_d   = pending_q;
      gap_d       = (gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
      ready_d     = 1'b0;
      out_last_d  = 1'b0;
`ifdef DDOT_PACK_STATS_EN
      group_count_d = group_count_q;
      pad_count_d   = pad_count_q;
      pad_sum       = {1'b0, pad_count_q} + 17'(3'd7 - last_idx);
`endif

      if (accept) begin
         fill_x_d[idx_q] = in_x;
         fill_y_d[idx_q] = in_y;
         idx_d           = idx_q + 3'd1;
      end

      if (complete) begin
         idx_d = 3'd0;
         if (!issue) begin
            pending_d   = 1'b1;
            pend_idx_d  = idx_q;
            pend_last_d = in_last;
         end
      end

      if (issue) begin
         for (int i = 0; i < 8; i++) begin
            if (3'(i) > last_idx) begin
               out_x_d[i] = PAD_VALUE;
               out_y_d[i] = PAD_VALUE;
            end else if (!pending_q && (3'(i) == idx_q)) begin
               out_x_d[i] = in_x;
               out_y_d[i] = in_y;
            end else begin
               out_x_d[i] = fill_x_q[i];
               out_y_d[i] = fill_y_q[i];
            end
         end
         ready_d    = 1'b1;
         out_last_d = group_last;
         pending_d  = 1'b0;
         idx_d      = 3'd0;
         gap_d      = GapReload;
`ifdef DDOT_PACK_STATS_EN
         group_count_d = group_count_q + 16'd1;
         pad_count_d   = pad_sum[16] ? 16'hFFFF : pad_sum[15:0];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            fill_x_q[i] <= '0;
            fill_y_q[i] <= '0;
            out_x_q[i]  <= '0;
            out_y_q[i]  <= '0;
         end
         idx_q       <= 3'd0;
         pend_idx_q  <= 3'd0;
         pend_last_q <= 1'b0;
         pending_q   <= 1'b0;
         gap_q       <= 8'd0;
         ready_q     <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef DDOT_PACK_STATS_EN
         group_count_q <= 16'd0;
         pad_count_q   <= 16'd0;
`endif
      end else begin
         fill_x_q    <= fill_x_d;
         fill_y_q    <= fill_y_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         idx_q       <= idx_d;
         pend_idx_q  <= pend_idx_d;
         pend_last_q <= pend_last_d;
         pending_q   <= pending_d;
         gap_q       <= gap_d;
         ready_q     <= ready_d;
         out_last_q  <= out_last_d;
`ifdef DDOT_PACK_STATS_EN
         group_count_q <= group_count_d;
         pad_count_q   <= pad_count_d;
`endif
      end
   end

   assign ready    = ready_q;
   assign out_last = out_last_q;
   assign x0 = out_x_q[0];
   assign x1 = out_x_q[1];
   assign x2 = out_x_q[2];
   assign x3 = out_x_q[3];
   assign x4 = out_x_q[4];
   assign x5 = out_x_q[5];
   assign x6 = out_x_q[6];
   assign x7 = out_x_q[7];
   assign y0 = out_y_q[0];
   assign y1 = out_y_q[1];
   assign y2 = out_y_q[2];
   assign y3 = out_y_q[3];
   assign y4 = out_y_q[4];
   assign y5 = out_y_q[5];
   assign y6 = out_y_q[6];
   assign y7 = out_y_q[7];
`ifdef DDOT_PACK_STATS_EN
   assign group_count = group_count_q;
   assign pad_count   = pad_count_q;
`endif

endmodule

// File: doc/ddot_lane_packer.md
Name: ddot_lane_packer

Overview:
- Upstream feeder for the 8-lane dot-product stage (basic_ddot).
- Accepts a serial stream of (x, y) float32 element pairs through a valid/ready handshake and packs them into 8-lane groups.
- Presents each group on x0..x7 / y0..y7 together with a one-cycle `ready` strobe, which drives basic_ddot's `ready` input.
- Pads short trailing groups (closed by `in_last`) with a neutral value, so the downstream product sum is unaffected.

Parameters:
- DATA_W, 32: element width in bits (IEEE-754 single).
- PAD_VALUE, 32'h00000000: value written to unfilled lanes of a short group (+0.0).
- MIN_GAP, 1: minimum number of cycles between consecutive `ready` strobes; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  packer can accept an element this cycle.
- in_x  in  DATA_W  x element.
- in_y  in  DATA_W  y element.
- in_last  in  1  element is the last of a vector; closes the current group.
- ready  out  1  one-cycle strobe: a new group is on x0..x7 / y0..y7.
- out_last  out  1  the group issued with this strobe was closed by `in_last`; valid only while `ready`=1.
- x0..x7  out  DATA_W each  packed x lanes; lane 0 holds the oldest element.
- y0..y7  out  DATA_W each  packed y lanes, same ordering as x.

Behaviour:
- Reset (rst=0, asynchronous):
  - ready=0, out_last=0, all x*/y* = 0.
  - Fill index = 0, pending = 0, gap counter = 0.
  - in_ready = 1 once rst deasserts.
  - Any partial group is discarded; this also applies to a reset asserted mid-operation.
- Accept: an element is accepted when in_valid && in_ready at a rising edge.
  - It is written into fill lane[idx] (x and y together).
  - idx then increments 0..7.
- Group completion occurs on an accepted element when idx==7 or in_last==1.
- Issue condition: (completion this cycle OR pending) AND gap counter == 0.
- On the issue edge:
  - Output bank ← fill lanes, with the completing element merged in and lanes above the last filled lane set to PAD_VALUE.
  - ready ← 1 for exactly one cycle; out_last ← in_last of the completing element.
  - idx ← 0, pending ← 0, gap counter ← MIN_GAP-1.
- Completion while the gap counter is nonzero:
  - pending ← 1 and in_ready = 0 until issue.
  - The held group contents are frozen.
- The gap counter decrements each cycle while it is nonzero.
- in_ready = ~pending (combinational from state; it does not depend on in_valid).
- Latency: completing element accepted at edge k → ready=1 and new lanes visible in cycle k+1, provided the gap counter has expired.
- Outputs x0..x7 / y0..y7 hold their value until the next issue; they never change while ready=0.
- Throughput with MIN_GAP=1: one element per cycle sustained, no stall.
- in_last asserted with in_valid=0 is ignored.
- in_last on the first element of a group → lane 0 is loaded, lanes 1..7 are padded.
- in_last on the 8th element → full group with out_last=1, no padding.
- No arithmetic is performed; data passes bit-exact.

Optional Feature:
- Macro DDOT_PACK_STATS_EN.
- Defined:
  - Adds output `group_count` [15:0]: increments on every issue, wraps 16'hFFFF→0, reset to 0.
  - Adds output `pad_count` [15:0]: adds the number of padded lanes on each issue, saturates at 16'hFFFF, reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset then 8 elements, each x=y=32'h3f800000, in_valid every cycle, in_last on the 8th → ready pulses once, the cycle after the 8th accept; all lanes 3f800000; out_last=1; in_ready stays 1.
- 3 elements x=32'h40000000, y=32'h3f800000, in_last on the 3rd → x0..x2=40000000, x3..x7=0, y3..y7=0; ready=1 and out_last=1 for exactly one cycle.
- MIN_GAP=12, 16 elements back-to-back with no in_last:
  - First strobe in the cycle after the 8th accept; out_last=0.
  - Second group completes 8 cycles after the first strobe → in_ready low for 4 cycles.
  - Second strobe exactly 12 cycles after the first; group-1 outputs stable throughout.
- Bursty in_valid (1,0,0,1,...), elements with x = 32'h00000001..32'h00000008 → lane order preserved (x0=1 … x7=8); no strobe before the 8th accept.
- Assert rst=0 after 5 of 8 elements, release, then send 8 elements x=y=32'h3f800000 → no strobe for the aborted group; next strobe carries only post-reset data.
- DDOT_PACK_STATS_EN defined, groups closed after 8, 3, and 1 elements → group_count=3, pad_count=0+5+7=12.
